// File: rtl/data_pack_if.sv
// ---------------------------------------------------------------------------
// data_pack_if
// Bundles the two streaming handshakes of the data_pack gearbox plus its
// framing-error flag, so the packer and its neighbours connect with a single
// port.
//
// Signals:
//   sym_valid/sym_ready       symbol handshake (producer -> packer)
//   sym_data[SYM_WIDTH]       narrow symbol, MSB is first in stream order
//   sym_first/sym_last        frame boundary markers on the symbol
//   word_valid/word_ready     word handshake (packer -> consumer)
//   word_data[WORD_WIDTH]     packed word, stream-first bit at MSB
//   word_bits[CNT_W]          count of valid MSB-aligned bits in word_data
//   word_last                 word closes the frame
//   frame_err                 sticky framing error flag
//
// Modports:
//   master  environment side (drives symbols, consumes words)
//   slave   packer side
// ---------------------------------------------------------------------------
interface data_pack_if #(
  parameter int SYM_WIDTH  = 7,
  parameter int WORD_WIDTH = 32,
  localparam int CNT_W     = $clog2(WORD_WIDTH + 1)
);
  logic                  sym_valid;
  logic                  sym_ready;
  logic [SYM_WIDTH-1:0]  sym_data;
  logic                  sym_first;
  logic                  sym_last;
  logic                  word_valid;
  logic                  word_ready;
  logic [WORD_WIDTH-1:0] word_data;
  logic [CNT_W-1:0]      word_bits;
  logic                  word_last;
  logic                  frame_err;

  modport master (
    output sym_valid, sym_data, sym_first, sym_last, word_ready,
    input  sym_ready, word_valid, word_data, word_bits, word_last, frame_err
  );

  modport slave (
    input  sym_valid, sym_data, sym_first, sym_last, word_ready,
    output sym_ready, word_valid, word_data, word_bits, word_last, frame_err
  );
endinterface

// File: rtl/data_pack.sv
// ---------------------------------------------------------------------------
// data_pack
// Collects narrow symbols (SYM_WIDTH bits) and repacks them MSB-first into
// wide words (WORD_WIDTH bits). sym_first/sym_last delimit frames; the last
// partial word of a frame is emitted left-aligned and zero-padded, with
// word_bits giving the number of valid bits. Full ready/valid backpressure
// on both sides.
//
// Ports:
//   clk     sole clock, rising edge
//   rst_n   synchronous active-low reset
//   bus     data_pack_if.slave: symbol input handshake, word output
//           handshake and frame_err
//
// Optional feature (compile-time macro DATA_PACK_FRAME_CHECK_EN):
//   defined   frame_err flags a sym_first arriving mid-frame, or a frame
//             that does not start with sym_first (sticky until reset)
//   undefined frame_err is tied low and no check logic is built
// ---------------------------------------------------------------------------
module data_pack #(
  parameter int SYM_WIDTH  = 7,
  parameter int WORD_WIDTH = 32,
  localparam int CNT_W     = $clog2(WORD_WIDTH + 1)
) (
  input logic        clk,
  input logic        rst_n,
  data_pack_if.slave bus
);

  localparam int ACC_W  = WORD_WIDTH + SYM_WIDTH - 1;
  localparam int FILL_W = $clog2(ACC_W + 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WORD_WIDTH);
  localparam logic [FILL_W-1:0] SYM_FILL  = FILL_W'(SYM_WIDTH);

  logic [0:0]            state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  wordValid_q, wordValid_d;
  logic [WORD_WIDTH-1:0] wordData_q, wordData_d;
  logic [CNT_W-1:0]      wordBits_q, wordBits_d;
  logic                  wordLast_q, wordLast_d;

  logic                  outFree;
  logic                  symReady;
  logic                  symAccept;
  logic                  wordLoad;
  logic [ACC_W-1:0]      accBase, accNew;
  logic [FILL_W-1:0]     fillBase, fillNew, fillRem;

  // Returns the n most recent valid bits of the accumulator, left-aligned in
  // a word and zero-padded. Appending a word of zeros and shifting right by n
  // brings acc[n-1] to the word MSB and masks stale bits above the fill.
  function automatic logic [WORD_WIDTH-1:0] leftAlign(
    input logic [ACC_W-1:0]  a,
    input logic [FILL_W-1:0] n
  );
    logic [ACC_W+WORD_WIDTH-1:0] t;
    t = {a, {WORD_WIDTH{1'b0}}} >> n;
    return t[WORD_WIDTH-1:0];
  endfunction

  // Handshake qualification and the append datapath. A first symbol starts
  // from an empty accumulator so any leftover residue is dropped.
  always_comb begin
    outFree   = !wordValid_q || bus.word_ready;
    symReady  = rst_n && (state_q == ST_ACCUM) && outFree;
    symAccept = symReady && bus.sym_valid;
    accBase   = bus.sym_first ? '0 : acc_q;
    fillBase  = bus.sym_first ? '0 : fill_q;
    accNew    = (accBase << SYM_WIDTH) | ACC_W'(bus.sym_data);
    fillNew   = fillBase + SYM_FILL;
    fillRem   = fillNew - WORD_FILL;
  end

  // Next-state logic. A symbol completes at most one full word because fill
  // always drops below WORD_WIDTH after a word is taken. When a frame ends
  // with both a full word and leftover bits, the leftover goes out from
  // FLUSH once the output register frees up.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    wordValid_d = wordValid_q && !bus.word_ready;
    wordData_d  = wordData_q;
    wordBits_d  = wordBits_q;
    wordLast_d  = wordLast_q;
    wordLoad    = 1'b0;

    if (state_q == ST_FLUSH) begin
      if (outFree) begin
        wordLoad   = 1'b1;
        wordData_d = leftAlign(acc_q, fill_q);
        wordBits_d = CNT_W'(fill_q);
        wordLast_d = 1'b1;
        fill_d     = '0;
        state_d    = ST_ACCUM;
      end
    end else if (symAccept) begin
      acc_d = accNew;
      if (fillNew >= WORD_FILL) begin
        wordLoad   = 1'b1;
        wordData_d = leftAlign(accNew, fillNew);
        wordBits_d = CNT_W'(WORD_WIDTH);
        wordLast_d = bus.sym_last && (fillRem == '0);
        fill_d     = fillRem;
        if (bus.sym_last && (fillRem != '0)) begin
          state_d = ST_FLUSH;
        end
      end else if (bus.sym_last) begin
        wordLoad   = 1'b1;
        wordData_d = leftAlign(accNew, fillNew);
        wordBits_d = CNT_W'(fillNew);
        wordLast_d = 1'b1;
        fill_d     = '0;
      end else begin
        fill_d = fillNew;
      end
    end

    if (wordLoad) begin
      wordValid_d = 1'b1;
    end
  end

  // State and output holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      fill_q      <= '0;
      wordValid_q <= 1'b0;
      wordData_q  <= '0;
      wordBits_q  <= '0;
      wordLast_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      wordValid_q <= wordValid_d;
      wordData_q  <= wordData_d;
      wordBits_q  <= wordBits_d;
      wordLast_q  <= wordLast_d;
    end
  end

  assign bus.sym_ready  = symReady;
  assign bus.word_valid = wordValid_q;
  assign bus.word_data  = wordData_q;
  assign bus.word_bits  = wordBits_q;
  assign bus.word_last  = wordLast_q;

`ifdef DATA_PACK_FRAME_CHECK_EN
  logic frameErr_q;
  logic expectFirst_q;

  // Framing check. expectFirst_q marks "between frames": set by reset and by
  // any word_last load, cleared by the next accepted symbol.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frameErr_q    <= 1'b0;
      expectFirst_q <= 1'b1;
    end else begin
      if (symAccept && ((bus.sym_first && (fill_q != '0)) ||
                        (!bus.sym_first && expectFirst_q))) begin
        frameErr_q <= 1'b1;
      end
      if (wordLoad && wordLast_d) begin
        expectFirst_q <= 1'b1;
      end else if (symAccept) begin
        expectFirst_q <= 1'b0;
      end
    end
  end

  assign bus.frame_err = frameErr_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_pack.sv
// ---------------------------------------------------------------------------
// tb_data_pack
// Scoreboard bench for data_pack. Accepted symbols feed a bit-queue model of
// the stream; the model pushes the words it expects into a queue, and a
// monitor pops and compares each word the DUT hands over. Directed sections
// cover reset, latency, FLUSH, backpressure, mid-frame reset and framing
// errors; a randomized section mixes frame lengths, data and word_ready.
// ---------------------------------------------------------------------------
module tb_data_pack;

  localparam int SYM_W  = 7;
  localparam int WORD_W = 32;

  typedef struct {
    logic [WORD_W-1:0] data;
    int                bits;
    logic              last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  data_pack_if #(.SYM_WIDTH(SYM_W), .WORD_WIDTH(WORD_W)) bus ();

  data_pack #(.SYM_WIDTH(SYM_W), .WORD_WIDTH(WORD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   total       = 0;
  int   bad         = 0;
  int   wordCount   = 0;
  int   readyMode   = 0;
  bit   expErr      = 1'b0;
  bit   expectFirst = 1'b1;
  exp_t sbQ[$];
  bit   pend[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic finishRun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic logic expFrameErr();
`ifdef DATA_PACK_FRAME_CHECK_EN
    return expErr;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: the stream is a queue of bits. Whole words leave as soon
  // as WORD_W bits are waiting; at frame end any remainder leaves as a
  // left-aligned partial word. A first symbol throws away pending bits.
  task automatic modelAccept(input logic [SYM_W-1:0] d, input logic f, input logic l);
    exp_t e;
    if (f) begin
      if (pend.size() > 0) expErr = 1'b1;
      pend.delete();
    end else if (expectFirst) begin
      expErr = 1'b1;
    end
    expectFirst = 1'b0;
    for (int i = SYM_W - 1; i >= 0; i--) pend.push_back(d[i]);
    while (pend.size() >= WORD_W) begin
      e.data = '0;
      for (int i = WORD_W - 1; i >= 0; i--) e.data[i] = pend.pop_front();
      e.bits = WORD_W;
      e.last = l && (pend.size() == 0);
      sbQ.push_back(e);
      if (e.last) expectFirst = 1'b1;
    end
    if (l && pend.size() > 0) begin
      e.data = '0;
      e.bits = pend.size();
      for (int i = WORD_W - 1; i >= WORD_W - e.bits; i--) e.data[i] = pend.pop_front();
      e.last = 1'b1;
      sbQ.push_back(e);
      expectFirst = 1'b1;
    end
  endtask

  // Monitor: samples one unit before each rising edge, so it sees exactly the
  // handshakes that edge will complete.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        pend.delete();
        sbQ.delete();
        expErr      = 1'b0;
        expectFirst = 1'b1;
      end else begin
        if (bus.word_valid && bus.word_ready) begin
          if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_word: actual=%0h required=none", bus.word_data);
          end else begin
            e = sbQ.pop_front();
            checkOutput("word_data", 64'(bus.word_data), 64'(e.data));
            checkOutput("word_bits", 64'(bus.word_bits), 64'(e.bits));
            checkOutput("word_last", 64'(bus.word_last), 64'(e.last));
            wordCount++;
          end
        end
        if (bus.sym_valid && bus.sym_ready) begin
          modelAccept(bus.sym_data, bus.sym_first, bus.sym_last);
        end
      end
    end
  end

  // word_ready driver: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    forever begin
      @(negedge clk);
      case (readyMode)
        0:       bus.word_ready = 1'b1;
        1:       bus.word_ready = ($urandom_range(0, 9) < 7);
        default: bus.word_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #600000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: actual=timeout required=finished");
    finishRun();
  end

  // Presents one symbol starting at a falling edge and holds it until the
  // packer takes it; returns at the falling edge after the accepting edge.
  task automatic applyStimulus(input logic [SYM_W-1:0] d, input logic f, input logic l);
    int waitCnt;
    bit done;
    waitCnt = 0;
    done    = 1'b0;
    bus.sym_valid = 1'b1;
    bus.sym_data  = d;
    bus.sym_first = f;
    bus.sym_last  = l;
    while (!done) begin
      #4;
      done = bus.sym_ready;
      @(negedge clk);
      if (!done) begin
        waitCnt++;
        if (waitCnt > 300) begin
          total++;
          bad++;
          $display("[TB] FAIL sym_accept_timeout: actual=stalled required=accepted");
          finishRun();
        end
      end
    end
    bus.sym_valid = 1'b0;
  endtask

  task automatic sendFrame(input int n, input int idleMax);
    logic [SYM_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = SYM_W'($urandom);
      applyStimulus(d, i == 0, i == n - 1);
      repeat ($urandom_range(0, idleMax)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (sbQ.size() != 0 || bus.word_valid) begin
      @(negedge clk);
      cnt++;
      if (cnt > 500) begin
        total++;
        bad++;
        $display("[TB] FAIL drain_timeout: actual=%0d_pending required=0", sbQ.size());
        finishRun();
      end
    end
  endtask

  task automatic doReset(input int cycles);
    rst_n         = 1'b0;
    bus.sym_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    checkOutput("rst_sym_ready",  64'(bus.sym_ready),  64'd0);
    checkOutput("rst_word_valid", 64'(bus.word_valid), 64'd0);
    checkOutput("rst_word_data",  64'(bus.word_data),  64'd0);
    checkOutput("rst_word_bits",  64'(bus.word_bits),  64'd0);
    checkOutput("rst_word_last",  64'(bus.word_last),  64'd0);
    checkOutput("rst_frame_err",  64'(bus.frame_err),  64'd0);
    rst_n = 1'b1;
    #4;
    checkOutput("post_rst_word_valid", 64'(bus.word_valid), 64'd0);
    checkOutput("post_rst_sym_ready",  64'(bus.sym_ready),  64'd1);
    @(negedge clk);
  endtask

  initial begin
    int               w0;
    logic [SYM_W-1:0] d6;
    bus.sym_valid  = 1'b0;
    bus.sym_data   = '0;
    bus.sym_first  = 1'b0;
    bus.sym_last   = 1'b0;
    bus.word_ready = 1'b1;
    readyMode      = 0;

    doReset(3);

    $display("[TB] 32-symbol frame");
    w0 = wordCount;
    sendFrame(32, 0);
    drain();
    checkOutput("t1_word_count", 64'(wordCount - w0), 64'd7);

    $display("[TB] 5 x 0x7F frame with flush");
    for (int i = 0; i < 5; i++) applyStimulus(7'h7F, i == 0, i == 4);
    #4;
    checkOutput("t2_flush_sym_ready", 64'(bus.sym_ready), 64'd0);
    checkOutput("t2_word0_data",      64'(bus.word_data), 64'hFFFF_FFFF);
    @(negedge clk);
    drain();

    $display("[TB] single-symbol frame");
    applyStimulus(7'h55, 1'b1, 1'b1);
    #4;
    checkOutput("t3_word_valid", 64'(bus.word_valid), 64'd1);
    checkOutput("t3_word_data",  64'(bus.word_data),  64'hAA00_0000);
    checkOutput("t3_word_bits",  64'(bus.word_bits),  64'd7);
    checkOutput("t3_word_last",  64'(bus.word_last),  64'd1);
    @(negedge clk);
    drain();

    $display("[TB] backpressure stall");
    readyMode = 2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) applyStimulus(SYM_W'($urandom), i == 0, 1'b0);
    d6            = SYM_W'($urandom);
    bus.sym_valid = 1'b1;
    bus.sym_data  = d6;
    bus.sym_first = 1'b0;
    bus.sym_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #4;
      checkOutput("t4_stall_sym_ready",  64'(bus.sym_ready),  64'd0);
      checkOutput("t4_stall_word_valid", 64'(bus.word_valid), 64'd1);
      if (sbQ.size() > 0) begin
        checkOutput("t4_stall_word_data", 64'(bus.word_data), 64'(sbQ[0].data));
      end else begin
        total++;
        bad++;
        $display("[TB] FAIL t4_expected_word: actual=none required=pending");
      end
      @(negedge clk);
    end
    readyMode = 0;
    applyStimulus(d6, 1'b0, 1'b0);
    applyStimulus(SYM_W'($urandom), 1'b0, 1'b0);
    applyStimulus(SYM_W'($urandom), 1'b0, 1'b1);
    drain();

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 3; i++) applyStimulus(SYM_W'($urandom), i == 0, 1'b0);
    doReset(1);
    w0 = wordCount;
    for (int i = 0; i < 5; i++) applyStimulus(7'h7F, i == 0, i == 4);
    drain();
    checkOutput("t5_word_count", 64'(wordCount - w0), 64'd2);

    $display("[TB] sym_first inside a frame");
    applyStimulus(SYM_W'($urandom), 1'b1, 1'b0);
    applyStimulus(SYM_W'($urandom), 1'b0, 1'b0);
    applyStimulus(SYM_W'($urandom), 1'b1, 1'b0);
    applyStimulus(SYM_W'($urandom), 1'b0, 1'b0);
    applyStimulus(SYM_W'($urandom), 1'b0, 1'b1);
    drain();
    checkOutput("t6_frame_err_model", 64'(bus.frame_err), 64'(expFrameErr()));
`ifdef DATA_PACK_FRAME_CHECK_EN
    checkOutput("t6_frame_err_set", 64'(bus.frame_err), 64'd1);
`else
    checkOutput("t6_frame_err_tied", 64'(bus.frame_err), 64'd0);
`endif

    $display("[TB] randomized frames");
    readyMode = 1;
    for (int f = 0; f < 25; f++) sendFrame($urandom_range(1, 12), 2);
    drain();
    readyMode = 0;
    checkOutput("final_frame_err", 64'(bus.frame_err), 64'(expFrameErr()));
    checkOutput("final_sb_empty",  64'(sbQ.size()),    64'd0);

    finishRun();
  end

endmodule
